// File: rtl/snake_pkg.sv
// Shared snake-game definitions: direction codes, game states and sound-event codes.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    GS_IDLE  = 2'b00,
    GS_RUN   = 2'b01,
    GS_PAUSE = 2'b10,
    GS_OVER  = 2'b11
  } game_state_e;

  typedef enum logic [2:0] {
    SND_NONE  = 3'd0,
    SND_EAT   = 3'd1,
    SND_TURN  = 3'd2,
    SND_DIE   = 3'd3,
    SND_START = 3'd4
  } sound_evt_e;

  // Bit positions in the packed button vector {center,right,left,down,up}.
  localparam int NUM_BTNS   = 5;
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;

endpackage

// File: rtl/key_debouncer.sv
// One key: two-flop synchronizer, stability counter and registered rising-edge strobe.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // NOTE: every register here is written with <= so all of them see the
  // pre-edge values of each other; blocking writes would collapse the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/input_processor.sv
// Button front end: five debounced keys -> direction, start/pause and long-press reset strobes.
// Define DIR_REPEAT_EN to re-strobe a single held direction every REPEAT_CYCLES.
module input_processor
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 100_000_000,
  parameter int REPEAT_CYCLES     = 20_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_in,
  input  logic       btn_down_in,
  input  logic       btn_left_in,
  input  logic       btn_right_in,
  input  logic       btn_center_in,
  output logic [1:0] dir_out,
  output logic       dir_vld_out,
  output logic       sp_evt_out,
  output logic       rst_evt_out,
  output logic [4:0] btn_lvl_out
);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_PRESS_CYCLES);

  // A one-cycle long press would put the reset strobe on top of the start/pause strobe.
  if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("input_processor: unsupported parameter set");
  end

  logic [NUM_BTNS-1:0] w_raw;
  logic [NUM_BTNS-1:0] w_level;
  logic [NUM_BTNS-1:0] w_rise;
  logic                w_dir_hit;
  logic                w_rep_fire;
  dir_e                w_dir_next;

  dir_e                r_dir;
  logic                r_dir_vld;
  logic                r_sp_evt;
  logic                r_rst_evt;
  logic [HW-1:0]       r_hold;

  assign w_raw = {btn_center_in, btn_right_in, btn_left_in, btn_down_in, btn_up_in};

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (w_raw[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g])
    );
  end

  // NOTE: outputs of always_comb get a default first so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_dir_hit  = |w_rise[BTN_RIGHT:BTN_UP];
    w_dir_next = r_dir;
    if      (w_rise[BTN_UP])    w_dir_next = DIR_UP;
    else if (w_rise[BTN_DOWN])  w_dir_next = DIR_DOWN;
    else if (w_rise[BTN_LEFT])  w_dir_next = DIR_LEFT;
    else if (w_rise[BTN_RIGHT]) w_dir_next = DIR_RIGHT;
  end

`ifdef DIR_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic          w_single_dir;
  logic [RW-1:0] r_rep_cnt;

  assign w_single_dir = $onehot(w_level[BTN_RIGHT:BTN_UP]);
  assign w_rep_fire   = w_single_dir && !w_dir_hit && (r_rep_cnt == REP_LAST);

  // A fresh edge restarts the period so repeats stay aligned to the latest edge strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt <= '0;
    end else if (w_dir_hit || !w_single_dir || w_rep_fire) begin
      r_rep_cnt <= '0;
    end else begin
      r_rep_cnt <= r_rep_cnt + RW'(1);
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir     <= DIR_UP;
      r_dir_vld <= 1'b0;
      r_sp_evt  <= 1'b0;
      r_rst_evt <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_dir     <= w_dir_next;
      r_dir_vld <= w_dir_hit | w_rep_fire;
      r_sp_evt  <= w_rise[BTN_CENTER];
      r_rst_evt <= w_level[BTN_CENTER] && (r_hold == HOLD_FIRE);
      // Saturating one past the fire value makes the reset strobe one-shot per hold.
      if (!w_level[BTN_CENTER])  r_hold <= '0;
      else if (r_hold != HOLD_SAT) r_hold <= r_hold + HW'(1);
    end
  end

  assign dir_out     = r_dir;
  assign dir_vld_out = r_dir_vld;
  assign sp_evt_out  = r_sp_evt;
  assign rst_evt_out = r_rst_evt;
  assign btn_lvl_out = w_level;

endmodule

// File: doc/input_processor.md
INPUT_PROCESSOR -- requirements
Module: input_processor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000 (10 ms at 100 MHz), stable cycles required before a debounced level changes.
REQ-002 Parameter LONG_PRESS_CYCLES, default 100_000_000 (1 s), center-button hold time that raises a reset event.
REQ-003 Parameter REPEAT_CYCLES, default 20_000_000, direction auto-repeat period; used only with DIR_REPEAT_EN.
REQ-004 Ports, in order:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- btn_up_in / btn_down_in / btn_left_in / btn_right_in  in  1 each  raw asynchronous buttons, active-high.
- btn_center_in  in  1  raw center button, active-high.
- dir_out  out  2  last accepted direction: UP=00, DOWN=01, LEFT=10, RIGHT=11.
- dir_vld_out  out  1  one-cycle strobe; dir_out is valid this cycle.
- sp_evt_out  out  1  one-cycle start/pause strobe.
- rst_evt_out  out  1  one-cycle game-reset strobe.
- btn_lvl_out  out  5  debounced levels {center,right,left,down,up}.
REQ-005 The single clock is clk; rst_n is asynchronous and active-low.

Function
REQ-006 Each raw input SHALL pass a two-flop synchronizer (reset 0) before any other logic.
REQ-007 Debounce: a per-button counter increments while the synchronized level differs from the debounced level.
- Any cycle where they match clears the counter to 0.
- When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
REQ-008 Raw-edge-to-debounced-level latency SHALL be exactly 2 + DEBOUNCE_CYCLES cycles for a clean edge.
REQ-009 A debounced rising edge SHALL produce its strobe one cycle after the debounced level rises; falling edges produce no strobe.
REQ-010 Direction rising edges SHALL update dir_out and pulse dir_vld_out in the same cycle.
REQ-011 If several direction edges occur in one cycle, exactly one dir_vld_out pulse SHALL be produced, with priority UP > DOWN > LEFT > RIGHT.
REQ-012 No reversal filtering SHALL be done here; opposite directions pass through unchanged.
REQ-013 Center rising edge SHALL pulse sp_evt_out.
REQ-014 Long press: a hold counter counts while the debounced center level is high.
- On reaching LONG_PRESS_CYCLES-1 it pulses rst_evt_out once and saturates.
- No further rst_evt_out until the button is released; release clears the counter.
REQ-015 A long press SHALL emit both sp_evt_out (at press) and rst_evt_out (at threshold); the two strobes never coincide.
REQ-016 All outputs SHALL be registered; all strobes are exactly one cycle wide.

Reset
REQ-017 On rst_n low, asynchronously clear:
- dir_out=UP, all strobes=0, btn_lvl_out=0;
- all counters and synchronizers to 0.
REQ-018 Reset asserted mid-debounce or mid-hold SHALL discard progress; no strobe is emitted on deassertion even if buttons are held (a held button is seen as a new press only after it debounces high again).

Configuration
REQ-019 Macro DIR_REPEAT_EN, when defined: while exactly one direction button is debounced high, re-pulse dir_vld_out with the same dir_out every REPEAT_CYCLES after the initial edge strobe; the repeat counter clears on release or on a new direction edge.
REQ-020 With DIR_REPEAT_EN undefined, no repeat logic exists and direction strobes occur only on rising edges.

Structure
REQ-021 Direction encodings (UP/DOWN/LEFT/RIGHT) SHALL live in the shared package snake_pkg, alongside the game-state and sound-event constants.
REQ-022 Sub-module key_debouncer (synchronizer + debounce counter + rise strobe) SHALL be instantiated five times; the long-press and direction logic stay in input_processor.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, REPEAT_CYCLES=8)
REQ-023 Clean UP press at cycle 0 -> btn_lvl_out[0] rises at cycle 6, dir_out=00 with dir_vld_out=1 at cycle 7 only.
REQ-024 btn_left_in toggling every 2 cycles for 20 cycles, then steady low -> no dir_vld_out, btn_lvl_out[2] stays 0.
REQ-025 DOWN and RIGHT pressed in the same cycle -> single dir_vld_out with dir_out=01.
REQ-026 Center held 40 cycles -> sp_evt_out once at press+7; rst_evt_out once, 20 cycles after the debounced level rises; nothing further until release.
REQ-027 rst_n pulsed low while center is held at hold count 10 -> outputs clear immediately; after release no rst_evt_out, dir_out=00.
REQ-028 With DIR_REPEAT_EN, RIGHT held 30 cycles after its edge strobe -> three further dir_vld_out pulses, 8 cycles apart, dir_out=11.
